// File: rtl/glb_dma.sv
// glb_dma: moves a contiguous run of words between a valid/ready stream and one
// GLB bank. The write path is combinational pass-through from the write
// stream to the GLB port. The read path issues addresses ahead of the
// consumer. A small return FIFO catches the data, and reads are throttled so
// that every read in flight already has a FIFO slot reserved.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a command; the only state with o_cmd_ready high
// WRITE | write-stream words pass straight through to the GLB
// READ  | issuing GLB reads while count < len and FIFO space allows
// DRAIN | every read issued; waiting for returns and for the FIFO to empty
// DONE  | single-cycle completion pulse (o_err too if the bank was 0)
module glb_dma #(
  parameter int BANK_WIDTH = 32,
  parameter int BANK_DEPTH = 8192,
  parameter int ADDR_W     = 13,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic                  i_cmd_dir,
  input  logic [1:0]            i_cmd_bank,
  input  logic [ADDR_W-1:0]     i_cmd_base,
  input  logic [ADDR_W:0]       i_cmd_len,
  input  logic                  i_wr_valid,
  output logic                  o_wr_ready,
  input  logic [BANK_WIDTH-1:0] i_wr_data,
  output logic                  o_rd_valid,
  input  logic                  i_rd_ready,
  output logic [BANK_WIDTH-1:0] o_rd_data,
  output logic [1:0]            o_glb_bank_sel,
  output logic                  o_glb_we,
  output logic [ADDR_W-1:0]     o_glb_addr,
  output logic [BANK_WIDTH-1:0] o_glb_wd,
  input  logic [BANK_WIDTH-1:0] i_glb_rd,
  output logic                  o_done,
  output logic                  o_err
);

  localparam int LEN_W  = ADDR_W + 1;
  localparam int SUM_W  = ADDR_W + 2;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int IF_W   = $clog2(RD_LAT + 1);
  localparam int OCC_W  = $clog2(FIFO_DEPTH + RD_LAT + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic                  dir_q;
  logic [1:0]            bank_q;
  logic [ADDR_W-1:0]     base_q;
  logic [LEN_W-1:0]      len_q;
  logic [LEN_W-1:0]      count;
  logic [LEN_W-1:0]      count_inc;

  logic [RD_LAT-1:0]     vld_sr;
  logic [IF_W-1:0]       inflight;
  logic                  capture;

  logic [BANK_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [FCNT_W-1:0]     fifo_count;
  logic                  pop;
  logic [OCC_W-1:0]      occ;

  logic [SUM_W-1:0]      addr_sum;
  logic [ADDR_W-1:0]     cur_addr;

  logic                  accept;
  logic                  wr_hs;
  logic                  issue;

  // reads still travelling through the GLB pipeline
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + IF_W'(vld_sr[i]);
    end
  end

  // shared datapath terms: current word address (wrapped) and FIFO occupancy
  always_comb begin
    count_inc = count + LEN_W'(1);
    addr_sum  = SUM_W'(base_q) + SUM_W'(count);
    if (addr_sum >= SUM_W'(BANK_DEPTH)) begin
      cur_addr = ADDR_W'(addr_sum - SUM_W'(BANK_DEPTH));
    end else begin
      cur_addr = ADDR_W'(addr_sum);
    end
    capture    = vld_sr[RD_LAT-1];
    o_rd_valid = (fifo_count != '0);
    pop        = o_rd_valid && i_rd_ready;
    o_rd_data  = o_rd_valid ? fifo_mem[rd_ptr] : '0;
    occ        = OCC_W'(inflight) + OCC_W'(fifo_count);
  end

  // next-state and GLB/stream outputs
  always_comb begin
    state_nxt      = state;
    o_cmd_ready    = 1'b0;
    o_wr_ready     = 1'b0;
    o_glb_bank_sel = 2'd0;
    o_glb_we       = 1'b0;
    o_glb_addr     = '0;
    o_glb_wd       = '0;
    o_done         = 1'b0;
    o_err          = 1'b0;
    accept         = 1'b0;
    wr_hs          = 1'b0;
    issue          = 1'b0;
    case (state)
      IDLE: begin
        o_cmd_ready = 1'b1;
        if (i_cmd_valid) begin
          accept = 1'b1;
          if ((i_cmd_bank == 2'd0) || (i_cmd_len == '0)) begin
            state_nxt = DONE;
          end else if (i_cmd_dir) begin
            state_nxt = READ;
          end else begin
            state_nxt = WRITE;
          end
        end
      end
      WRITE: begin
        o_wr_ready     = 1'b1;
        o_glb_bank_sel = bank_q;
        // dir_q is always 0 here; the qualifier stops a corrupted state from
        // ever writing the GLB on behalf of a read command
        o_glb_we       = i_wr_valid && !dir_q;
        o_glb_wd       = i_wr_data;
        o_glb_addr     = cur_addr;
        wr_hs          = i_wr_valid;
        if (wr_hs && (count_inc == len_q)) begin
          state_nxt = DONE;
        end
      end
      READ: begin
        // bank_sel stays put: the GLB output mux follows it combinationally
        o_glb_bank_sel = bank_q;
        o_glb_addr     = cur_addr;
        issue          = (occ < OCC_W'(FIFO_DEPTH)) && (count < len_q);
        if (issue && (count_inc == len_q)) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        o_glb_bank_sel = bank_q;
        if ((inflight == '0) && (fifo_count == '0) && !capture) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        o_done    = 1'b1;
        o_err     = (bank_q == 2'd0);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // command latch and word counter
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      dir_q  <= 1'b0;
      bank_q <= 2'd0;
      base_q <= '0;
      len_q  <= '0;
      count  <= '0;
    end else if (accept) begin
      dir_q  <= i_cmd_dir;
      bank_q <= i_cmd_bank;
      base_q <= i_cmd_base;
      len_q  <= i_cmd_len;
      count  <= '0;
    end else if (wr_hs || issue) begin
      count <= count_inc;
    end
  end

  // read-valid shift register: an issue reaches the last tap RD_LAT-1 cycles
  // later and is captured on the following edge
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      vld_sr <= '0;
    end else begin
      vld_sr[0] <= issue;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_sr[i] <= vld_sr[i-1];
      end
    end
  end

  // return FIFO pointers and occupancy
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (capture) begin
        wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({capture, pop})
        2'b10:   fifo_count <= fifo_count + FCNT_W'(1);
        2'b01:   fifo_count <= fifo_count - FCNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // return FIFO storage; contents are don't-care while the count is zero
  always_ff @(posedge i_clk) begin
    if (capture) begin
      fifo_mem[wr_ptr] <= i_glb_rd;
    end
  end

endmodule

// File: tb/tb_glb_dma.sv
// tb_glb_dma: drives glb_dma against a small GLB model. Every command's
// outcome is judged against a word-level reference memory: the words written
// to each bank, the words read back in order, completion latency and error.
module tb_glb_dma;

  localparam int BW    = 32;
  localparam int DEPTH = 8192;
  localparam int AW    = 13;
  localparam int RDL   = 2;
  localparam int FD    = 4;

  logic          clk = 1'b0;
  logic          i_rst;
  logic          i_cmd_valid;
  logic          o_cmd_ready;
  logic          i_cmd_dir;
  logic [1:0]    i_cmd_bank;
  logic [AW-1:0] i_cmd_base;
  logic [AW:0]   i_cmd_len;
  logic          i_wr_valid;
  logic          o_wr_ready;
  logic [BW-1:0] i_wr_data;
  logic          o_rd_valid;
  logic          i_rd_ready;
  logic [BW-1:0] o_rd_data;
  logic [1:0]    o_glb_bank_sel;
  logic          o_glb_we;
  logic [AW-1:0] o_glb_addr;
  logic [BW-1:0] o_glb_wd;
  logic [BW-1:0] i_glb_rd;
  logic          o_done;
  logic          o_err;

  always #5 clk = ~clk;

  glb_dma #(
    .BANK_WIDTH(BW), .BANK_DEPTH(DEPTH), .ADDR_W(AW), .RD_LAT(RDL), .FIFO_DEPTH(FD)
  ) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_dir(i_cmd_dir),
    .i_cmd_bank(i_cmd_bank), .i_cmd_base(i_cmd_base), .i_cmd_len(i_cmd_len),
    .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready), .i_wr_data(i_wr_data),
    .o_rd_valid(o_rd_valid), .i_rd_ready(i_rd_ready), .o_rd_data(o_rd_data),
    .o_glb_bank_sel(o_glb_bank_sel), .o_glb_we(o_glb_we), .o_glb_addr(o_glb_addr),
    .o_glb_wd(o_glb_wd), .i_glb_rd(i_glb_rd), .o_done(o_done), .o_err(o_err)
  );

  // GLB model: three banks, read data appears RD_LAT edges after the address,
  // output mux follows the current bank_sel combinationally
  logic [BW-1:0] glb_mem [0:3][0:DEPTH-1];
  logic [BW-1:0] p1 [0:3];
  logic [BW-1:0] p2 [0:3];

  always @(posedge clk) begin
    for (int b = 1; b < 4; b++) begin
      p1[b] <= glb_mem[b][o_glb_addr];
      p2[b] <= p1[b];
    end
    if (o_glb_we && (o_glb_bank_sel != 2'd0)) glb_mem[o_glb_bank_sel][o_glb_addr] <= o_glb_wd;
  end

  always_comb i_glb_rd = (o_glb_bank_sel == 2'd0) ? '0 : p2[o_glb_bank_sel];

  // reference model: what each bank word should hold, and whether it is known
  logic [BW-1:0] ref_mem [0:3][0:DEPTH-1];
  bit            ref_ok  [0:3][0:DEPTH-1];
  int            rg_bank[$];
  int            rg_base[$];
  int            rg_len[$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One full command from offer to o_done. Returns the cycle (counted from the
  // accept edge) on which o_done was seen, and the first o_rd_valid cycle.
  task automatic run_cmd(input logic dir, input logic [1:0] bank, input int base, input int len,
                         input int wr_pct, input int rd_pct, input int stall,
                         output int lat, output int first_rv, output logic err_seen);
    logic [BW-1:0] wdata[$];
    logic [BW-1:0] rdq[$];
    int            wbank[$];
    int            waddr[$];
    logic [BW-1:0] wwd[$];
    int            idx;
    int            valid_cmd;
    int            a;
    int            n;
    bit            done_seen;
    for (int i = 0; i < len; i++) wdata.push_back($urandom);
    lat       = -1;
    first_rv  = -1;
    err_seen  = 1'b0;
    idx       = 0;
    done_seen = 1'b0;
    valid_cmd = ((bank != 2'd0) && (len != 0)) ? 1 : 0;
    @(negedge clk);
    i_cmd_valid = 1'b1;
    i_cmd_dir   = dir;
    i_cmd_bank  = bank;
    i_cmd_base  = base[AW-1:0];
    i_cmd_len   = len[AW:0];
    #1 chk("cmd_ready_idle", 32'(o_cmd_ready), 32'd1);
    for (int cyc = 1; cyc <= 600 && !done_seen; cyc++) begin
      @(negedge clk);
      i_cmd_valid = 1'b0;
      i_wr_valid  = (!dir && (idx < len) && ($urandom_range(99) < wr_pct));
      i_wr_data   = (idx < len) ? wdata[idx] : $urandom;
      i_rd_ready  = (cyc > stall) && ($urandom_range(99) < rd_pct);
      #1;
      if ((stall > 0) && (cyc == stall) && (len > FD)) begin
        chk("stall_issue_addr", 32'(o_glb_addr), 32'((base + FD) % DEPTH));
        chk("stall_rd_valid", 32'(o_rd_valid), 32'd1);
      end
      if (o_glb_we) begin
        wbank.push_back(int'(o_glb_bank_sel));
        waddr.push_back(int'(o_glb_addr));
        wwd.push_back(o_glb_wd);
      end
      if (o_rd_valid && (first_rv < 0)) first_rv = cyc;
      if (o_rd_valid && i_rd_ready) rdq.push_back(o_rd_data);
      if (o_wr_ready && i_wr_valid) idx++;
      if (o_done) begin
        done_seen = 1'b1;
        lat       = cyc;
        err_seen  = o_err;
        chk("done_bus_quiet", 32'({o_cmd_ready, o_glb_we, o_glb_bank_sel, o_glb_addr}), 32'd0);
      end
    end
    i_wr_valid = 1'b0;
    i_rd_ready = 1'b0;
    chk("done_seen", 32'(done_seen), 32'd1);
    if (!dir) begin
      chk("wr_count", 32'(wbank.size()), 32'(valid_cmd ? len : 0));
      n = (wbank.size() < len) ? wbank.size() : len;
      for (int i = 0; i < n; i++) begin
        a = (base + i) % DEPTH;
        chk($sformatf("wr_bank[%0d]", i), 32'(wbank[i]), 32'(bank));
        chk($sformatf("wr_addr[%0d]", i), 32'(waddr[i]), 32'(a));
        chk($sformatf("wr_data[%0d]", i), wwd[i], wdata[i]);
      end
      if (valid_cmd != 0) begin
        for (int i = 0; i < len; i++) begin
          a = (base + i) % DEPTH;
          ref_mem[bank][a] = wdata[i];
          ref_ok[bank][a]  = 1'b1;
        end
        rg_bank.push_back(int'(bank));
        rg_base.push_back(base);
        rg_len.push_back(len);
      end
    end else begin
      chk("rd_no_writes", 32'(wbank.size()), 32'd0);
      chk("rd_count", 32'(rdq.size()), 32'(valid_cmd ? len : 0));
      n = (rdq.size() < len) ? rdq.size() : len;
      for (int i = 0; i < n; i++) begin
        a = (base + i) % DEPTH;
        if (ref_ok[bank][a]) chk($sformatf("rd_data[%0d]@%0d", i, a), rdq[i], ref_mem[bank][a]);
      end
    end
  endtask

  typedef struct {
    logic       dir;
    logic [1:0] bank;
    int         base;
    int         len;
    int         rd_pct;
    int         stall;
    int         exp_lat;
    int         exp_first;
    logic       exp_err;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    int   frv;
    logic es;
    int   seen;
    int   r;
    int   k;
    int   off;
    int   ln;
    logic [1:0] bk;
    int   bs;

    tbl[0]  = '{1'b0, 2'd2, 16,   3, 100, 0,  4, -1, 1'b0};
    tbl[1]  = '{1'b1, 2'd2, 16,   3, 100, 0,  8,  4, 1'b0};
    tbl[2]  = '{1'b0, 2'd3, 100,  8, 100, 0,  9, -1, 1'b0};
    tbl[3]  = '{1'b1, 2'd3, 100,  8, 100, 10, -1, 4, 1'b0};
    tbl[4]  = '{1'b0, 2'd1, 8190, 4, 100, 0,  5, -1, 1'b0};
    tbl[5]  = '{1'b1, 2'd1, 8190, 4, 100, 0,  9,  4, 1'b0};
    tbl[6]  = '{1'b0, 2'd0, 40,   5, 100, 0,  1, -1, 1'b1};
    tbl[7]  = '{1'b1, 2'd0, 40,   5, 100, 0,  1, -1, 1'b1};
    tbl[8]  = '{1'b0, 2'd2, 300,  0, 100, 0,  1, -1, 1'b0};
    tbl[9]  = '{1'b1, 2'd3, 300,  0, 100, 0,  1, -1, 1'b0};
    tbl[10] = '{1'b1, 2'd2, 16,   3, 50,  0, -1,  4, 1'b0};
    tbl[11] = '{1'b0, 2'd1, 8191, 1, 100, 0,  2, -1, 1'b0};

    i_rst = 1'b0; i_cmd_valid = 1'b0; i_cmd_dir = 1'b0; i_cmd_bank = 2'd0;
    i_cmd_base = '0; i_cmd_len = '0; i_wr_valid = 1'b0; i_wr_data = '0; i_rd_ready = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ctrl", 32'({o_cmd_ready, o_wr_ready, o_rd_valid, o_glb_we, o_glb_bank_sel, o_done, o_err}),
        32'h80);
    chk("rst_addr", 32'(o_glb_addr), 32'd0);
    chk("rst_rd_data", o_rd_data, 32'd0);
    chk("rst_wd", o_glb_wd, 32'd0);
    @(negedge clk);
    i_rst = 1'b1;

    // directed table
    for (int t = 0; t < 12; t++) begin
      run_cmd(tbl[t].dir, tbl[t].bank, tbl[t].base, tbl[t].len, 100, tbl[t].rd_pct, tbl[t].stall,
              lat, frv, es);
      if (tbl[t].exp_lat >= 0) chk($sformatf("t%0d_done_lat", t), 32'(lat), 32'(tbl[t].exp_lat));
      if (tbl[t].exp_first >= 0) chk($sformatf("t%0d_first_rv", t), 32'(frv), 32'(tbl[t].exp_first));
      chk($sformatf("t%0d_err", t), 32'(es), 32'(tbl[t].exp_err));
    end

    // command held valid through DONE: not taken until IDLE
    @(negedge clk);
    i_cmd_valid = 1'b1; i_cmd_bank = 2'd0; i_cmd_dir = 1'b0; i_cmd_len = 14'd5;
    #1 chk("hold_idle0", 32'(o_cmd_ready), 32'd1);
    @(negedge clk);
    #1 chk("hold_done", 32'({o_done, o_err, o_cmd_ready}), 32'b110);
    @(negedge clk);
    #1 chk("hold_idle1", 32'({o_done, o_cmd_ready}), 32'b01);
    @(negedge clk);
    i_cmd_valid = 1'b0;
    #1 chk("hold_done2", 32'({o_done, o_err}), 32'b11);
    @(negedge clk);
    #1 chk("hold_back", 32'(o_cmd_ready), 32'd1);

    // reset in the middle of a read with data in flight
    i_cmd_valid = 1'b1; i_cmd_dir = 1'b1; i_cmd_bank = 2'd3; i_cmd_base = 13'd100;
    i_cmd_len = 14'd8; i_rd_ready = 1'b0;
    @(negedge clk);
    i_cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk("mid_read_busy", 32'(o_cmd_ready), 32'd0);
    i_rst = 1'b0;
    @(negedge clk);
    i_rst = 1'b1;
    #1;
    chk("rst_mid_ready", 32'(o_cmd_ready), 32'd1);
    chk("rst_mid_outs", 32'({o_rd_valid, o_done, o_glb_bank_sel, o_glb_we}), 32'd0);
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1 if (o_done || o_rd_valid) seen++;
    end
    chk("rst_mid_silent", 32'(seen), 32'd0);
    run_cmd(1'b1, 2'd3, 100, 8, 100, 100, 0, lat, frv, es);
    chk("post_rst_lat", 32'(lat), 32'd13);

    // randomized commands against the reference memory
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(99);
      if (r < 40) begin
        bk = 2'($urandom_range(1, 3));
        bs = ($urandom_range(1) == 1) ? $urandom_range(8180, 8191) : $urandom_range(0, 8191);
        ln = $urandom_range(1, 12);
        run_cmd(1'b0, bk, bs, ln, $urandom_range(40, 100), 100, 0, lat, frv, es);
        chk($sformatf("rnd%0d_err", n), 32'(es), 32'd0);
      end else if (r < 85) begin
        k   = $urandom_range(rg_bank.size() - 1);
        off = $urandom_range(rg_len[k] - 1);
        ln  = $urandom_range(1, rg_len[k] - off);
        bs  = (rg_base[k] + off) % DEPTH;
        run_cmd(1'b1, 2'(rg_bank[k]), bs, ln, 100, $urandom_range(30, 100),
                (ln > FD) ? 8 : 0, lat, frv, es);
        chk($sformatf("rnd%0d_first_rv", n), 32'(frv), 32'd4);
        chk($sformatf("rnd%0d_err", n), 32'(es), 32'd0);
      end else begin
        bk = ($urandom_range(1) == 1) ? 2'd0 : 2'($urandom_range(1, 3));
        ln = (bk == 2'd0) ? $urandom_range(0, 20) : 0;
        run_cmd(1'($urandom_range(1)), bk, $urandom_range(0, 8191), ln, 100, 100, 0, lat, frv, es);
        chk($sformatf("rnd%0d_lat", n), 32'(lat), 32'd1);
        chk($sformatf("rnd%0d_err", n), 32'(es), 32'(bk == 2'd0));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
